// File: rtl/led_seq_pkg.sv
// ============================================================================
// Module      : led_seq_pkg
// Description : Mode encodings and seed-pattern helper for the LED sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package led_seq_pkg;

  localparam int c_LED_MAX = 32;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_BLINK  = 2'd0;
  localparam mode_t MODE_ALT    = 2'd1;
  localparam mode_t MODE_CHASE  = 2'd2;
  localparam mode_t MODE_BOUNCE = 2'd3;

  // Seed applied whenever a mode is loaded; bits at or above n are zero.
  function automatic logic [c_LED_MAX-1:0] initial_pattern(input mode_t mode, input int n);
    logic [c_LED_MAX-1:0] v;
    v = '0;
    case (mode)
      MODE_ALT: begin
        for (int i = 0; i < c_LED_MAX; i++) begin
          if ((i < n) && ((i % 2) == 0)) v[i] = 1'b1;
        end
      end
      MODE_CHASE, MODE_BOUNCE: v[0] = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/led_pattern_sequencer_tick_divider.sv
// ============================================================================
// Module      : tick_divider
// Description : Enable-gated prescaler producing a step strobe every DIV cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_divider #(
  parameter int DIV = 4
) (
  input  logic i_CLK,
  input  logic i_RST_N,
  input  logic i_EN,
  input  logic i_CLR,
  output logic o_STEP
);

  localparam int c_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [c_W-1:0] c_LAST = c_W'(DIV - 1);

  logic [c_W-1:0] r_cnt;
  logic           w_last;

  assign w_last = (r_cnt == c_LAST);

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      r_cnt <= '0;
    end else if (i_CLR) begin
      r_cnt <= '0;
    end else if (i_EN) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

  // A clear wins over a coincident wrap so no step escapes alongside a load.
  assign o_STEP = i_EN & ~i_CLR & w_last;

endmodule

`default_nettype wire

// File: rtl/led_pattern_sequencer.sv
// ============================================================================
// Module      : led_pattern_sequencer
// Description : Blink / alternate / chase / bounce LED engine with step prescaler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int CLK_HZ  = 50000000,
  parameter int STEP_HZ = 2,
  parameter int N_LED   = 4
) (
  input  logic             i_CLK,
  input  logic             i_RST_N,
  input  logic             i_EN,
  input  logic [1:0]       i_MODE,
  input  logic             i_MODE_LOAD,
  output logic [N_LED-1:0] o_LED,
  output logic             o_TICK,
  output logic [1:0]       o_MODE
);

  localparam int   c_DIV   = CLK_HZ / STEP_HZ;
  localparam logic c_DIR_UP = 1'b0;
  localparam logic c_DIR_DN = 1'b1;

  logic             w_step;
  logic [N_LED-1:0] r_led, w_led_nxt, w_seed, w_shl, w_shr, w_rotl;
  mode_t            r_mode, w_mode_nxt;
  logic             r_dir, w_dir_nxt;
  logic             r_tick, w_tick_nxt;

  tick_divider #(
    .DIV (c_DIV)
  ) u_tick_divider (
    .i_CLK   (i_CLK),
    .i_RST_N (i_RST_N),
    .i_EN    (i_EN),
    .i_CLR   (i_MODE_LOAD),
    .o_STEP  (w_step)
  );

  assign w_seed = N_LED'(initial_pattern(i_MODE, N_LED));
  assign w_shl  = r_led << 1;
  assign w_shr  = r_led >> 1;
  assign w_rotl = (r_led << 1) | (r_led >> (N_LED - 1));

  always_comb begin
    w_led_nxt  = r_led;
    w_mode_nxt = r_mode;
    w_dir_nxt  = r_dir;
    w_tick_nxt = 1'b0;
    if (i_MODE_LOAD) begin
      w_mode_nxt = i_MODE;
      w_led_nxt  = w_seed;
      w_dir_nxt  = c_DIR_UP;
    end else if (w_step) begin
      w_tick_nxt = 1'b1;
      case (r_mode)
        MODE_BLINK, MODE_ALT: w_led_nxt = ~r_led;
        MODE_CHASE:           w_led_nxt = w_rotl;
        default: begin
          // A single LED has nowhere to bounce to, so it simply holds.
          if (N_LED == 1) begin
            w_led_nxt = r_led;
          end else if (r_dir == c_DIR_UP) begin
            w_led_nxt = w_shl;
            if (w_shl[N_LED-1]) w_dir_nxt = c_DIR_DN;
          end else begin
            w_led_nxt = w_shr;
            if (w_shr[0]) w_dir_nxt = c_DIR_UP;
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      r_led  <= '0;
      r_mode <= MODE_BLINK;
      r_dir  <= c_DIR_UP;
      r_tick <= 1'b0;
    end else begin
      r_led  <= w_led_nxt;
      r_mode <= w_mode_nxt;
      r_dir  <= w_dir_nxt;
      r_tick <= w_tick_nxt;
    end
  end

  assign o_LED  = r_led;
  assign o_TICK = r_tick;
  assign o_MODE = r_mode;

endmodule

`default_nettype wire

// File: tb/tb_led_pattern_sequencer.sv
// ============================================================================
// Module      : tb_led_pattern_sequencer
// Description : Directed self-checking bench for led_pattern_sequencer (DIV=4, 4 LEDs).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_pattern_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic       load;
  logic [3:0] led;
  logic       tick;
  logic [1:0] mode_q;

  int n_checks = 0;
  int n_pass   = 0;

  led_pattern_sequencer #(
    .CLK_HZ  (8),
    .STEP_HZ (2),
    .N_LED   (4)
  ) dut (
    .i_CLK       (clk),
    .i_RST_N     (rst_n),
    .i_EN        (en),
    .i_MODE      (mode),
    .i_MODE_LOAD (load),
    .o_LED       (led),
    .o_TICK      (tick),
    .o_MODE      (mode_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  // Three quiet edges, then a step edge presenting exp with a tick.
  task automatic expect_step(input string tag, input logic [3:0] prev, input logic [3:0] exp);
    for (int i = 0; i < 3; i++) begin
      edge1();
      chk({tag, "_hold_tick"}, {31'd0, tick}, 32'd0);
      chk({tag, "_hold_led"}, {28'd0, led}, {28'd0, prev});
    end
    edge1();
    chk({tag, "_led"}, {28'd0, led}, {28'd0, exp});
    chk({tag, "_tick"}, {31'd0, tick}, 32'd1);
  endtask

  task automatic do_load(input logic [1:0] m);
    load = 1'b1;
    mode = m;
    edge1();
    load = 1'b0;
  endtask

  logic [3:0] chase_seq  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] bounce_seq [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                 4'b0100, 4'b0010, 4'b0001, 4'b0010};
  logic [3:0] alt_seq    [3] = '{4'b0101, 4'b1010, 4'b0101};

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 2'd0; load = 1'b0;
    repeat (3) edge1();
    chk("rst_led", {28'd0, led}, 32'd0);
    chk("rst_tick", {31'd0, tick}, 32'd0);
    chk("rst_mode", {30'd0, mode_q}, 32'd0);

    // Make state non-zero, then assert reset asynchronously mid-cycle.
    rst_n = 1'b1; en = 1'b1;
    do_load(2'd2);
    chk("pre_rst_led", {28'd0, led}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_led", {28'd0, led}, 32'd0);
    chk("async_rst_tick", {31'd0, tick}, 32'd0);
    chk("async_rst_mode", {30'd0, mode_q}, 32'd0);
    edge1();
    rst_n = 1'b1;
    expect_step("blink1", 4'b0000, 4'b1111);
    expect_step("blink2", 4'b1111, 4'b0000);

    // CHASE
    do_load(2'd2);
    chk("chase_mode", {30'd0, mode_q}, 32'd2);
    chk("chase_seed", {28'd0, led}, {28'd0, chase_seq[0]});
    chk("chase_seed_tick", {31'd0, tick}, 32'd0);
    for (int i = 1; i < 5; i++) expect_step("chase", chase_seq[i-1], chase_seq[i]);

    // BOUNCE
    do_load(2'd3);
    chk("bounce_seed", {28'd0, led}, {28'd0, bounce_seq[0]});
    for (int i = 1; i < 8; i++) expect_step("bounce", bounce_seq[i-1], bounce_seq[i]);

    // ALT
    do_load(2'd1);
    chk("alt_seed", {28'd0, led}, {28'd0, alt_seq[0]});
    for (int i = 1; i < 3; i++) expect_step("alt", alt_seq[i-1], alt_seq[i]);

    // Freeze during CHASE after two enabled edges.
    do_load(2'd2);
    repeat (2) edge1();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      edge1();
      chk("freeze_led", {28'd0, led}, 32'h1);
      chk("freeze_tick", {31'd0, tick}, 32'd0);
    end
    en = 1'b1;
    edge1();
    chk("resume1_tick", {31'd0, tick}, 32'd0);
    chk("resume1_led", {28'd0, led}, 32'h1);
    edge1();
    chk("resume2_led", {28'd0, led}, 32'h2);
    chk("resume2_tick", {31'd0, tick}, 32'd1);

    // Load colliding with a BLINK step edge.
    do_load(2'd0);
    chk("blink_seed", {28'd0, led}, 32'd0);
    repeat (3) edge1();
    do_load(2'd2);
    chk("coll_led", {28'd0, led}, 32'h1);
    chk("coll_tick", {31'd0, tick}, 32'd0);
    chk("coll_mode", {30'd0, mode_q}, 32'd2);
    expect_step("coll_next", 4'b0001, 4'b0010);

    // Load while disabled.
    en = 1'b0;
    do_load(2'd3);
    chk("dis_mode", {30'd0, mode_q}, 32'd3);
    chk("dis_led", {28'd0, led}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      edge1();
      chk("dis_hold_led", {28'd0, led}, 32'h1);
      chk("dis_hold_tick", {31'd0, tick}, 32'd0);
    end
    en = 1'b1;
    expect_step("dis_next", 4'b0001, 4'b0010);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
Parametrised LED pattern engine for the board LED bank. It generates a slow step tick from the system clock and drives N_LED outputs through one of four run-time-selectable patterns: blink, alternate, chase and bounce. It sits directly behind the top-level LED pins and can be enabled, frozen or re-moded by surrounding control logic.

Parameters:
CLK_HZ, 50000000, input clock frequency in Hz
STEP_HZ, 2, pattern steps per second; DIV = CLK_HZ/STEP_HZ (integer), DIV >= 2 required
N_LED, 4, number of LED outputs, >= 1

Ports:
i_CLK  input  1  system clock, all state on rising edge
i_RST_N  input  1  asynchronous active-low reset
i_EN  input  1  run enable; low freezes prescaler and pattern
i_MODE  input  2  requested mode: 0 BLINK, 1 ALT, 2 CHASE, 3 BOUNCE
i_MODE_LOAD  input  1  single-cycle strobe; captures i_MODE
o_LED  output  N_LED  LED drive, active-high, registered
o_TICK  output  1  one-cycle pulse, high in the cycle a step is applied
o_MODE  output  2  current mode register

Behaviour:
- Reset (i_RST_N low, asynchronous, no clock needed): o_LED=0, o_TICK=0, o_MODE=BLINK, prescaler=0, bounce direction=up.
- Prescaler: counts 0..DIV-1 on each enabled edge. The edge at count DIV-1 wraps it to 0 and is a step edge. Width is clog2(DIV).
- First step edge is the DIV-th enabled edge after reset release. Steps then follow every DIV enabled cycles.
- o_TICK is registered and is 1 exactly in the cycle after a step edge, coincident with the new o_LED value.
- i_EN low: prescaler, pattern, direction and mode are all held, and o_TICK=0. i_MODE_LOAD is still honoured. On re-enable, counting resumes from the held count.
- i_MODE_LOAD high at an edge:
  - o_MODE<=i_MODE and prescaler<=0.
  - o_LED<=initial pattern: BLINK all 0; ALT bit0=1 with alternating bits (…0101); CHASE and BOUNCE one-hot bit0.
  - Direction<=up.
  - Load has priority over a coincident step: no step is applied and o_TICK=0 next cycle.
- Step update per mode:
  - BLINK: o_LED <= ~o_LED.
  - ALT: o_LED <= ~o_LED.
  - CHASE: rotate left by 1; bit N_LED-1 wraps to bit0.
  - BOUNCE: if direction up, shift left; when the shifted result has bit N_LED-1 set, direction<=down. If direction down, shift right; when the result has bit0 set, direction<=up. Sequence for N_LED=4: 0001,0010,0100,1000,0100,0010,0001,0010…
- Boundary cases:
  - N_LED=1: CHASE and BOUNCE hold 1. ALT toggles like BLINK.
  - If o_LED is not one-hot when a mode is reached by reset, the pattern still evolves deterministically. Load always re-seeds, so this case does not occur in practice.
- No combinational path from any input to any output.

Decomposition:
- Package led_seq_pkg holds:
  - mode constants MODE_BLINK=0, MODE_ALT=1, MODE_CHASE=2, MODE_BOUNCE=3;
  - 2-bit mode typedef;
  - function initial_pattern(mode, n).
- Sub-module tick_divider (params DIV; ports i_CLK, i_RST_N, i_EN, i_CLR, o_STEP) owns the prescaler. The top owns the mode, pattern and direction registers.

Test Plan:
All scenarios use CLK_HZ=8, STEP_HZ=2 (DIV=4), N_LED=4.
- Reset: hold i_RST_N low 3 cycles, then assert it low again between edges -> o_LED=0000, o_TICK=0, o_MODE=0 immediately. Release with i_EN=1 -> o_LED=1111 with o_TICK=1 after 4th edge, 0000 after 8th edge.
- CHASE: pulse load with mode 2 -> o_LED=0001, then every 4 cycles 0010, 0100, 1000, 0001, each with a one-cycle o_TICK.
- BOUNCE: load mode 3 -> 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010 at 4-cycle spacing. ALT: load mode 1 -> 0101, then 1010, then 0101.
- Freeze: in CHASE, drop i_EN for 10 cycles after 2 enabled edges -> o_LED constant, o_TICK=0. After re-enable, the next step occurs on the 2nd enabled edge.
- Load/step collision: pulse i_MODE_LOAD (mode 2) on the step edge of BLINK -> o_LED=0001, o_TICK=0, next step 4 edges later.
- Load while disabled: i_EN=0, load mode 3 -> o_MODE=3, o_LED=0001, no further change until i_EN=1.
